// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with wait states
//
// Purpose:
//   Accepts one load/store at a time from the pipeline MEM stage, models a
//   word-organised big-endian data store with WAIT_CYCLES wait states and
//   returns a one-cycle MEM_Ready pulse carrying extended load data or
//   store completion. MEM_Err flags faulted requests during the Ready cycle.
//
// Parameters:
//   ADDR_W       word-address width, depth = 2**ADDR_W words
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   MEM_Req      request valid, held with Opcode/Addr/WData while stalled
//   MEM_Opcode   MIPS load/store opcode
//   MEM_Addr     byte address
//   MEM_WData    store data (sb/sh use the low byte/half)
//   MEM_RData    registered, extended load result
//   MEM_Ready    one-cycle completion pulse
//   MEM_Err      fault flag, only with MEM_Ready
//   MEM_Stall    MEM_Req & ~MEM_Ready

module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_Req,
   input  logic [5:0]  MEM_Opcode,
   input  logic [31:0] MEM_Addr,
   input  logic [31:0] MEM_WData,
   output logic [31:0] MEM_RData,
   output logic        MEM_Ready,
   output logic        MEM_Err,
   output logic        MEM_Stall
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic       ZERO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic [5:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   logic              accept;
   logic              enter_resp;
   logic [5:0]        cur_op;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic              is_load;
   logic              is_store;
   logic              need_word;
   logic              need_half;
   logic              valid_op;
   logic              out_of_range;
   logic              fault;
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       mem_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_data;
   logic [31:0]       store_word;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (MEM_Req) begin
               state_next = ZERO_WAIT ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The decrement that brings the counter to zero is the RESP-entry edge.
            if (count <= 4'd1) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      MEM_Ready = (state == ST_RESP);
      MEM_Err   = (state == ST_RESP) & err_q;
      MEM_Stall = MEM_Req & ~MEM_Ready;
      MEM_RData = rdata_q;
   end

   assign accept     = (state == ST_IDLE) & MEM_Req;
   assign enter_resp = (state_next == ST_RESP) & (state != ST_RESP);

   // ---------------------------------------------------------------------
   // Request view: live inputs on the accept edge, latched copy afterwards.
   // With zero wait states the accept edge is also the RESP-entry edge, so
   // the latched copy would not yet be valid there.
   // ---------------------------------------------------------------------
   always_comb begin
      if (state == ST_IDLE) begin
         cur_op    = MEM_Opcode;
         cur_addr  = MEM_Addr;
         cur_wdata = MEM_WData;
      end else begin
         cur_op    = op_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
   end

   // ---------------------------------------------------------------------
   // Opcode / alignment / range decode
   // ---------------------------------------------------------------------
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      need_word = 1'b0;
      need_half = 1'b0;
      valid_op  = 1'b1;
      case (cur_op)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin
            is_load   = 1'b1;
            need_half = 1'b1;
         end
         OP_LW: begin
            is_load   = 1'b1;
            need_word = 1'b1;
         end
         OP_SB: is_store = 1'b1;
         OP_SH: begin
            is_store  = 1'b1;
            need_half = 1'b1;
         end
         OP_SW: begin
            is_store  = 1'b1;
            need_word = 1'b1;
         end
         default: valid_op = 1'b0;
      endcase

      // Any address bit above the byte span of the array is a fault, not an alias.
      out_of_range = ((cur_addr >> (ADDR_W + 2)) != 32'd0);

      fault = ~valid_op
            | (need_word & (cur_addr[1:0] != 2'b00))
            | (need_half & cur_addr[0])
            | out_of_range;
   end

   // ---------------------------------------------------------------------
   // Big-endian lane extraction and read-modify-write merge
   // ---------------------------------------------------------------------
   assign word_idx = cur_addr[ADDR_W+1:2];
   assign mem_word = mem[word_idx];

   always_comb begin
      case (cur_addr[1:0])
         2'd0:    byte_sel = mem_word[31:24];
         2'd1:    byte_sel = mem_word[23:16];
         2'd2:    byte_sel = mem_word[15:8];
         default: byte_sel = mem_word[7:0];
      endcase
      half_sel = cur_addr[1] ? mem_word[15:0] : mem_word[31:16];

      case (cur_op)
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'd0, byte_sel};
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'd0, half_sel};
         OP_LW:   load_data = mem_word;
         default: load_data = 32'd0;
      endcase

      store_word = mem_word;
      case (cur_op)
         OP_SB: begin
            case (cur_addr[1:0])
               2'd0:    store_word[31:24] = cur_wdata[7:0];
               2'd1:    store_word[23:16] = cur_wdata[7:0];
               2'd2:    store_word[15:8]  = cur_wdata[7:0];
               default: store_word[7:0]   = cur_wdata[7:0];
            endcase
         end
         OP_SH: begin
            if (cur_addr[1]) begin
               store_word[15:0] = cur_wdata[15:0];
            end else begin
               store_word[31:16] = cur_wdata[15:0];
            end
         end
         OP_SW:   store_word = cur_wdata;
         default: store_word = mem_word;
      endcase
   end

   // ---------------------------------------------------------------------
   // Request latch, wait counter, response registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         op_q    <= 6'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         count   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         if (accept) begin
            op_q    <= MEM_Opcode;
            addr_q  <= MEM_Addr;
            wdata_q <= MEM_WData;
            count   <= WAIT_LOAD;
         end else if ((state == ST_WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
         end

         if (enter_resp) begin
            err_q <= fault;
            // Stores leave the previous load result in place.
            if (fault) begin
               rdata_q <= 32'd0;
            end else if (is_load) begin
               rdata_q <= load_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Storage: not reset. RESET gates the write so an aborted store whose
   // RESP-entry edge coincides with reset never lands.
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESET && enter_resp && is_store && !fault) begin
         mem[word_idx] <= store_word;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder

module tb_dmem_responder;

   localparam logic [5:0] LB  = 6'h20;
   localparam logic [5:0] LH  = 6'h21;
   localparam logic [5:0] LW  = 6'h23;
   localparam logic [5:0] LBU = 6'h24;
   localparam logic [5:0] LHU = 6'h25;
   localparam logic [5:0] SB  = 6'h28;
   localparam logic [5:0] SH  = 6'h29;
   localparam logic [5:0] SW  = 6'h2B;

   logic        clk;
   logic        rst;

   logic        req2;
   logic [5:0]  op2;
   logic [31:0] addr2;
   logic [31:0] wd2;
   logic [31:0] rdata2;
   logic        ready2;
   logic        err2;
   logic        stall2;

   logic        req0;
   logic [5:0]  op0;
   logic [31:0] addr0;
   logic [31:0] wd0;
   logic [31:0] rdata0;
   logic        ready0;
   logic        err0;
   logic        stall0;

   int passed;
   int total;

   logic [31:0] rd;
   logic        e;
   int          lat;
   int          stl;
   int          first;
   int          second;
   logic        e_first;

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
      .CLK        (clk),
      .RESET      (rst),
      .MEM_Req    (req2),
      .MEM_Opcode (op2),
      .MEM_Addr   (addr2),
      .MEM_WData  (wd2),
      .MEM_RData  (rdata2),
      .MEM_Ready  (ready2),
      .MEM_Err    (err2),
      .MEM_Stall  (stall2)
   );

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
      .CLK        (clk),
      .RESET      (rst),
      .MEM_Req    (req0),
      .MEM_Opcode (op0),
      .MEM_Addr   (addr0),
      .MEM_WData  (wd0),
      .MEM_RData  (rdata0),
      .MEM_Ready  (ready0),
      .MEM_Err    (err0),
      .MEM_Stall  (stall0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request on the WAIT_CYCLES=2 instance, starting at a negedge
   // in IDLE; returns at the negedge of the following IDLE cycle.
   task automatic run2(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
      logic seen;
      op2   = op;
      addr2 = a;
      wd2   = wd;
      req2  = 1'b1;
      lat   = 0;
      stl   = 0;
      seen  = 1'b0;
      #1;
      if (stall2) stl++;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (ready2) seen = 1'b1;
         else if (stall2) stl++;
      end
      chk("ready_seen", {31'd0, seen}, 32'd1);
      rd   = rdata2;
      e    = err2;
      req2 = 1'b0;
      @(negedge clk);
      chk("ready_low_after_resp", {31'd0, ready2}, 32'd0);
      chk("err_low_after_resp", {31'd0, err2}, 32'd0);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b1;
      req2 = 1'b1; op2 = 6'd0; addr2 = 32'd0; wd2 = 32'd0;
      req0 = 1'b0; op0 = 6'd0; addr0 = 32'd0; wd0 = 32'd0;

      // Reset values
      @(negedge clk);
      chk("rst_rdata", rdata2, 32'd0);
      chk("rst_ready", {31'd0, ready2}, 32'd0);
      chk("rst_err", {31'd0, err2}, 32'd0);
      chk("rst_stall_follows_req1", {31'd0, stall2}, 32'd1);
      req2 = 1'b0;
      #1;
      chk("rst_stall_follows_req0", {31'd0, stall2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Preload and basic lw latency / stall length
      run2(SW, 32'h40, 32'h11223344);
      chk("sw_pre_lat", lat, 32'd3);
      chk("sw_pre_err", {31'd0, e}, 32'd0);
      run2(LW, 32'h40, 32'd0);
      chk("lw_lat", lat, 32'd3);
      chk("lw_stall_cycles", stl, 32'd3);
      chk("lw_rdata", rd, 32'h11223344);
      chk("lw_err", {31'd0, e}, 32'd0);

      // Partial stores
      run2(SB, 32'h43, 32'h000000AA);
      run2(SH, 32'h40, 32'h0000BEEF);
      run2(LW, 32'h40, 32'd0);
      chk("rmw_word", rd, 32'hBEEF33AA);

      // Byte-lane loads on 0x80FF7F01
      run2(SW, 32'h40, 32'h80FF7F01);
      run2(LB, 32'h41, 32'd0);
      chk("lb_41", rd, 32'hFFFFFFFF);
      run2(LBU, 32'h41, 32'd0);
      chk("lbu_41", rd, 32'h000000FF);
      run2(LB, 32'h40, 32'd0);
      chk("lb_40", rd, 32'hFFFFFF80);
      run2(LH, 32'h42, 32'd0);
      chk("lh_42", rd, 32'h00007F01);
      run2(LHU, 32'h40, 32'd0);
      chk("lhu_40", rd, 32'h000080FF);

      // Faults
      run2(LW, 32'h42, 32'd0);
      chk("flt_lw_mis_err", {31'd0, e}, 32'd1);
      chk("flt_lw_mis_rdata", rd, 32'd0);
      chk("flt_lw_mis_lat", lat, 32'd3);
      run2(LW, 32'h40, 32'd0);
      chk("flt_word_unchanged", rd, 32'h80FF7F01);
      run2(SW, 32'h0, 32'h0BADF00D);
      run2(SW, 32'h00001000, 32'h5555AAAA);
      chk("flt_range_err", {31'd0, e}, 32'd1);
      chk("flt_range_lat", lat, 32'd3);
      run2(LW, 32'h0, 32'd0);
      chk("flt_range_no_write", rd, 32'h0BADF00D);
      run2(6'h00, 32'h40, 32'd0);
      chk("flt_opcode_err", {31'd0, e}, 32'd1);
      chk("flt_opcode_lat", lat, 32'd3);
      run2(SH, 32'h41, 32'h00001234);
      chk("flt_sh_mis_err", {31'd0, e}, 32'd1);
      run2(LW, 32'h40, 32'd0);
      chk("flt_sh_no_write", rd, 32'h80FF7F01);

      // Back-to-back, WAIT_CYCLES=2, Req held continuously
      op2 = SW; addr2 = 32'h44; wd2 = 32'hDEADBEEF; req2 = 1'b1;
      first = -1; second = -1; e_first = 1'b1; rd = 32'd0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (ready2) begin
            if (first < 0) begin
               first   = i;
               e_first = err2;
               op2     = LW;
               wd2     = 32'd0;
            end else begin
               second = i;
               rd     = rdata2;
               break;
            end
         end
      end
      req2 = 1'b0;
      @(negedge clk);
      chk("b2b_w2_first", first, 32'd3);
      chk("b2b_w2_gap", second - first, 32'd4);
      chk("b2b_w2_err", {31'd0, e_first}, 32'd0);
      chk("b2b_w2_rdata", rd, 32'hDEADBEEF);

      // Back-to-back, WAIT_CYCLES=0
      op0 = SW; addr0 = 32'h44; wd0 = 32'hDEADBEEF; req0 = 1'b1;
      first = -1; second = -1; rd = 32'd0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (ready0) begin
            if (first < 0) begin
               first = i;
               op0   = LW;
               wd0   = 32'd0;
            end else begin
               second = i;
               rd     = rdata0;
               break;
            end
         end
      end
      req0 = 1'b0;
      @(negedge clk);
      chk("b2b_w0_first", first, 32'd1);
      chk("b2b_w0_gap", second - first, 32'd2);
      chk("b2b_w0_rdata", rd, 32'hDEADBEEF);

      // Req dropped during WAIT still completes the store
      op2 = SW; addr2 = 32'h4C; wd2 = 32'h0F0F0F0F; req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      first = -1;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (ready2) begin
            first = i;
            break;
         end
      end
      chk("drop_req_ready_at", first, 32'd3);
      @(negedge clk);
      run2(LW, 32'h4C, 32'd0);
      chk("drop_req_store_done", rd, 32'h0F0F0F0F);

      // Reset during WAIT aborts a store
      run2(SW, 32'h48, 32'hCAFEF00D);
      run2(LW, 32'h48, 32'd0);
      chk("rst_pre_old", rd, 32'hCAFEF00D);
      op2 = SW; addr2 = 32'h48; wd2 = 32'h12345678; req2 = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_rdata", rdata2, 32'd0);
      chk("midrst_ready", {31'd0, ready2}, 32'd0);
      chk("midrst_err", {31'd0, err2}, 32'd0);
      op2 = LW; wd2 = 32'd0;
      @(negedge clk);
      chk("midrst_stall", {31'd0, stall2}, 32'd1);
      rst = 1'b0;
      run2(LW, 32'h48, 32'd0);
      chk("midrst_reaccept_lat", lat, 32'd3);
      chk("midrst_no_write", rd, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
